// File: rtl/display_update_if.sv
// Result-to-display bus between the CPU result register and the
// seven-segment driver.
//   value     : two's-complement result presented by the CPU side
//   negative  : sign of the displayed value
//   digit0..4 : BCD digits of the magnitude, digit0 least significant
//   update    : one-cycle pulse when the displayed value changes
//   busy      : controller is converting or holding
interface display_update_if;
  logic [15:0] value;
  logic        negative;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic [3:0]  digit4;
  logic        update;
  logic        busy;

  modport master (
    output value,
    input  negative, digit0, digit1, digit2, digit3, digit4, update, busy
  );

  modport slave (
    input  value,
    output negative, digit0, digit1, digit2, digit3, digit4, update, busy
  );
endinterface

// File: rtl/display_update_ctrl.sv
// Rate-limited binary-to-decimal display controller. Watches a 16-bit
// signed result, converts it to sign + five BCD digits with an iterative
// double-dabble (16 shift cycles) and holds each shown value for at least
// HOLD_CYCLES clocks.
//   clk : system clock, rising edge
//   KEY : synchronous active-low reset
//   bus : display_update_if slave (value in; sign, digits, update, busy out)
module display_update_ctrl #(
  parameter int unsigned HOLD_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             KEY,
  display_update_if.slave  bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       src_q, src_d;
  logic              init_q, init_d;
  logic              sign_q, sign_d;
  logic [15:0]       mag_q, mag_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [19:0]       disp_q, disp_d;
  logic              neg_q, neg_d;
  logic              upd_q, upd_d;
  logic              busy_q, busy_d;
  logic [19:0]       bcd_adj;

  // Next-state and datapath for the capture / convert / show / hold sequence
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    init_d  = init_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    neg_d   = neg_q;
    upd_d   = 1'b0;
    busy_d  = busy_q;
    bcd_adj = bcd_q;

    // Double-dabble correction: any digit >= 5 gets +3 before the shift
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (init_q || (bus.value != src_q)) begin
          src_d   = bus.value;
          sign_d  = bus.value[15];
          init_d  = 1'b0;
          // Modulo-16 negation: -32768 maps to 0x8000 read as unsigned 32768
          mag_d   = bus.value[15] ? 16'(~bus.value + 16'd1) : bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj[18:0], mag_q, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        disp_d = bcd_q;
        neg_d  = sign_q;
        upd_d  = 1'b1;
        hold_d = HOLD_LOAD;
        if (HOLD_CYCLES == 0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (hold_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (!KEY) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      init_q  <= 1'b1;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      init_q  <= init_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      neg_q   <= neg_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.negative = neg_q;
  assign bus.digit0   = disp_q[3:0];
  assign bus.digit1   = disp_q[7:4];
  assign bus.digit2   = disp_q[11:8];
  assign bus.digit3   = disp_q[15:12];
  assign bus.digit4   = disp_q[19:16];
  assign bus.update   = upd_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Bench for display_update_ctrl: three instances (hold 4, 50 and 0 cycles)
// share clock and reset; each test drives one instance and checks it
// against a decimal model through a per-instance expectation queue.
module tb_display_update_ctrl;

  logic clk = 1'b0;
  logic key;
  int   checks   = 0;
  int   failures = 0;

  logic [20:0] q4[$];
  logic [20:0] q50[$];
  logic [20:0] q0[$];

  display_update_if if4();
  display_update_if if50();
  display_update_if if0();

  display_update_ctrl #(.HOLD_CYCLES(4))  u4  (.clk(clk), .KEY(key), .bus(if4));
  display_update_ctrl #(.HOLD_CYCLES(50)) u50 (.clk(clk), .KEY(key), .bus(if50));
  display_update_ctrl #(.HOLD_CYCLES(0))  u0  (.clk(clk), .KEY(key), .bus(if0));

  always #5 clk = ~clk;

  // Reference: {negative, digit4..digit0} from plain integer arithmetic
  function automatic logic [20:0] exp_pack(input logic [15:0] v);
    int m;
    logic [20:0] r;
    m = v[15] ? (65536 - int'(v)) : int'(v);
    r = '0;
    r[20] = v[15];
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [20:0] obs(input int which);
    case (which)
      4:  return {if4.negative, if4.digit4, if4.digit3, if4.digit2, if4.digit1, if4.digit0};
      50: return {if50.negative, if50.digit4, if50.digit3, if50.digit2, if50.digit1, if50.digit0};
      default: return {if0.negative, if0.digit4, if0.digit3, if0.digit2, if0.digit1, if0.digit0};
    endcase
  endfunction

  function automatic logic upd(input int which);
    case (which)
      4:  return if4.update;
      50: return if50.update;
      default: return if0.update;
    endcase
  endfunction

  function automatic logic bsy(input int which);
    case (which)
      4:  return if4.busy;
      50: return if50.busy;
      default: return if0.busy;
    endcase
  endfunction

  // Count edges until an update pulse; -1 when the budget runs out
  task automatic wait_upd(input int which, input int budget, output int waited);
    int  i;
    bit  seen;
    waited = -1;
    seen = 0;
    i = 0;
    while (!seen && i < budget) begin
      @(posedge clk); #1;
      i++;
      if (upd(which)) begin
        seen = 1;
        waited = i;
      end
    end
  endtask

  task automatic wait_idle(input int which, input int budget, output bit ok);
    int i;
    i = 0;
    while (bsy(which) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    ok = !bsy(which);
  endtask

  task automatic test_reset();
    int w;
    int extra;
    logic [20:0] e;
    key = 1'b0;
    if4.value = 16'd0;
    if50.value = 16'd0;
    if0.value = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs(4) !== 21'd0) begin
      failures++;
      $display("FAIL reset_out got=%h exp=%h", obs(4), 21'd0);
    end
    checks++;
    if ({upd(4), bsy(4)} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=00", {upd(4), bsy(4)});
    end
    q4.push_back(exp_pack(16'd0));
    key = 1'b1;
    wait_upd(4, 40, w);
    checks++;
    if (w !== 18) begin
      failures++;
      $display("FAIL reset_latency got=%0d exp=18", w);
    end
    e = q4.pop_front();
    checks++;
    if (obs(4) !== e) begin
      failures++;
      $display("FAIL reset_digits got=%h exp=%h", obs(4), e);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bsy(4) !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_hold got=%b exp=1", bsy(4));
    end
    @(posedge clk); #1;
    checks++;
    if (bsy(4) !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_end got=%b exp=0", bsy(4));
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (upd(4)) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL reset_no_repeat got=%0d exp=0", extra);
    end
  endtask

  task automatic test_convert();
    logic [15:0] vals[4];
    logic [20:0] e;
    int w;
    bit ok;
    vals[0] = 16'd12345;
    vals[1] = 16'hFFFF;
    vals[2] = 16'h8000;
    vals[3] = 16'h7FFF;
    for (int n = 0; n < 4; n++) begin
      wait_idle(4, 100, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL conv_idle_%0d got=busy exp=idle", n);
      end
      if4.value = vals[n];
      q4.push_back(exp_pack(vals[n]));
      wait_upd(4, 40, w);
      checks++;
      if (w !== 18) begin
        failures++;
        $display("FAIL conv_latency_%0d got=%0d exp=18", n, w);
      end
      e = q4.pop_front();
      checks++;
      if (obs(4) !== e) begin
        failures++;
        $display("FAIL conv_digits_%0d got=%h exp=%h", n, obs(4), e);
      end
    end
  endtask

  task automatic test_hold();
    logic [20:0] e;
    logic [20:0] at_first;
    int w;
    int first;
    int held_bad;
    int extra;
    bit ok;
    wait_idle(50, 200, ok);
    if50.value = 16'd100;
    q50.push_back(exp_pack(16'd100));
    wait_upd(50, 40, w);
    checks++;
    if (w !== 18) begin
      failures++;
      $display("FAIL hold_first_latency got=%0d exp=18", w);
    end
    e = q50.pop_front();
    checks++;
    if (obs(50) !== e) begin
      failures++;
      $display("FAIL hold_first_digits got=%h exp=%h", obs(50), e);
    end
    q50.push_back(exp_pack(16'd300));
    first = 0;
    held_bad = 0;
    extra = 0;
    at_first = '0;
    for (int i = 1; i <= 120; i++) begin
      if (i == 5)  if50.value = 16'd200;
      if (i == 10) if50.value = 16'd300;
      @(posedge clk); #1;
      if (upd(50)) begin
        if (first == 0) begin
          first = i;
          at_first = obs(50);
        end else begin
          extra++;
        end
      end
      if (first == 0 && obs(50) !== exp_pack(16'd100)) held_bad++;
    end
    checks++;
    if (held_bad !== 0) begin
      failures++;
      $display("FAIL hold_stable got=%0d exp=0", held_bad);
    end
    checks++;
    if (first !== 68) begin
      failures++;
      $display("FAIL hold_next_latency got=%0d exp=68", first);
    end
    e = q50.pop_front();
    checks++;
    if (at_first !== e) begin
      failures++;
      $display("FAIL hold_latest_digits got=%h exp=%h", at_first, e);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL hold_single got=%0d exp=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e;
    int w;
    bit ok;
    wait_idle(4, 100, ok);
    if4.value = 16'd500;
    repeat (7) @(posedge clk);
    #1;
    key = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs(4) !== 21'd0) begin
      failures++;
      $display("FAIL rst_mid_out got=%h exp=%h", obs(4), 21'd0);
    end
    checks++;
    if ({upd(4), bsy(4)} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_ctl got=%b exp=00", {upd(4), bsy(4)});
    end
    if4.value = 16'd777;
    q4.push_back(exp_pack(16'd777));
    key = 1'b1;
    wait_upd(4, 40, w);
    checks++;
    if (w !== 18) begin
      failures++;
      $display("FAIL rst_mid_latency got=%0d exp=18", w);
    end
    e = q4.pop_front();
    checks++;
    if (obs(4) !== e) begin
      failures++;
      $display("FAIL rst_mid_digits got=%h exp=%h", obs(4), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [20:0] e;
    int seen;
    bit ok;
    wait_idle(0, 100, ok);
    @(posedge clk); #1;
    seen = 0;
    for (int k = 1; k <= 95; k++) begin
      v = 16'((k - 1) * 2749 + 13);
      if0.value = v;
      if (((k - 1) % 18) == 0) q0.push_back(exp_pack(v));
      @(posedge clk); #1;
      if (upd(0)) begin
        seen++;
        checks++;
        if ((k % 18) !== 0) begin
          failures++;
          $display("FAIL b2b_period got=edge%0d exp=multiple_of_18", k);
        end
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL b2b_digits got=%h exp=none", obs(0));
        end else begin
          e = q0.pop_front();
          if (obs(0) !== e) begin
            failures++;
            $display("FAIL b2b_digits got=%h exp=%h", obs(0), e);
          end
        end
      end
    end
    checks++;
    if (seen !== 5) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=5", seen);
    end
    q0.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    key = 1'b0;
    if4.value = '0;
    if50.value = '0;
    if0.value = '0;
    @(posedge clk); #1;
    test_reset();
    test_convert();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_update_ctrl.md
# display_update_ctrl

Sequential controller between `cpu_16bit`'s `result_reg` and the seven-segment driver `hex_display`. It watches the 16-bit signed result and, when the value changes, runs an iterative double-dabble conversion to sign plus five decimal digits. It then latches the digits for display and holds them for a programmable minimum time so that fast-changing results do not flicker. It replaces the combinational `bin16_to_hex` path with a multi-cycle, rate-limited one.

## Interface
- `HOLD_CYCLES`, default 5_000_000: minimum clocks the display holds a value after an update (0.1 s at 50 MHz). 0 means no hold.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `KEY`  in  1  synchronous, active-low reset.
- `value`  in  16  two's-complement result to display. Sampled only in IDLE.
- `negative`  out  1  sign of the displayed value.
- `digit0`..`digit4`  out  4 each  decimal digits of the magnitude. `digit0` is the least significant digit. Each is in the range 0–9.
- `update`  out  1  one-cycle pulse when the outputs take a new value.
- `busy`  out  1  high in SHIFT, DONE and HOLD.

## Operation
- States: IDLE, SHIFT, DONE, HOLD.
- Internal registers:
  - `src[15:0]`: last captured value.
  - `init`: set by reset.
  - `mag[15:0]`: magnitude shift register.
  - `bcd[19:0]`: BCD accumulator.
  - `cnt[4:0]`: shift counter.
  - `hold_cnt`: counter sized to hold `HOLD_CYCLES`.
- IDLE:
  - Trigger condition: `init == 1` or `value != src`.
  - When triggered, on that edge:
    - `src <= value`, `sign <= value[15]`, `init <= 0`.
    - `mag <= value[15] ? -value : value`, treated as 16-bit unsigned, so -32768 gives 0x8000 = 32768.
    - `bcd <= 0`, `cnt <= 0`.
    - Go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each cycle performs one double-dabble step.
  - Any BCD nibble of `bcd` that is ≥5 gets +3.
  - Then shift `{bcd, mag}` left by 1.
  - `cnt` increments; after the 16th step go to DONE.
- DONE, one cycle:
  - `digitN <= bcd[4N+3:4N]`, `negative <= sign`, `update <= 1`.
  - Go to HOLD, or to IDLE if `HOLD_CYCLES == 0`.
  - `hold_cnt` loads `HOLD_CYCLES - 1`.
- HOLD: decrement `hold_cnt`; go to IDLE at 0.
- In SHIFT, DONE and HOLD, `value` is ignored. A change in those states is seen on return to IDLE, so only the latest value is converted and intermediate values are dropped.
- Zero is never shown as negative. The sign comes from `value[15]`, and 0 has `value[15] = 0`.
- Width rules:
  - Negation is 16-bit modulo.
  - Maximum magnitude is 32768, so `digit4` ≤ 3.
  - `bcd` never overflows 20 bits.

## Timing
- Reset (`KEY` = 0 at an edge):
  - state IDLE, `init` = 1, `src` = 0.
  - `negative` = 0, all digits = 0, `update` = 0, `busy` = 0.
  - Reset overrides every state. Reset mid-SHIFT or mid-HOLD abandons the operation, and the outputs return to 0 at that edge.
- Capture edge E0 is in IDLE. SHIFT occupies edges E1..E16. Outputs and `update` register at E17, so latency is 17 clocks from capture.
- `update` is high for exactly one cycle, following E17.
- `busy` is high from E0+ until the edge on which HOLD exits.
- The earliest next capture is 17 + `HOLD_CYCLES` + 1 clocks after E0, since IDLE always lasts at least one cycle.
- Outputs are stable between `update` pulses; they never show partial results.
- First release of reset always produces one conversion and one `update` pulse, even for `value` = 0.

## Test plan
- Release reset with `value` = 0, `HOLD_CYCLES` = 4 → after 17 clocks, one `update` pulse, digits 0,0,0,0,0, `negative` = 0. `busy` is low again 4 clocks after DONE. No further `update` while `value` stays 0.
- `value` = 12345 while idle → 17 clocks later, `digit4`..`digit0` = 1,2,3,4,5 and `negative` = 0.
- `value` = 0xFFFF (-1) → `negative` = 1, digits 0,0,0,0,1. `value` = 0x8000 → `negative` = 1, digits 3,2,7,6,8. `value` = 0x7FFF → `negative` = 0, digits 3,2,7,6,7.
- Change `value` 100 → 200 → 300 during HOLD (`HOLD_CYCLES` = 50) → outputs stay at the previous value until HOLD ends. Exactly one further conversion follows, showing 300. `update` pulses once for it.
- Assert `KEY` = 0 at SHIFT step 8 → next cycle outputs are 0, `busy` = 0, state IDLE. On release, conversion restarts from the current `value` and completes in 17 clocks.
- `HOLD_CYCLES` = 0 with `value` changing every clock → conversions run back to back, one per 18 clocks. Each `update` shows the `value` captured at its own E0.
